// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - store size encodings and store-buffer entry layout
package store_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Word address only; the byte offset is folded into be.
  typedef struct packed {
    logic [31:2] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } store_entry_t;

endpackage

// File: rtl/store_lane_align.sv
// rtl/store_lane_align.sv - byte-lane replication, byte enables and misalign detect
module store_lane_align
  import store_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misalign
);

  // Any size with bit 1 set is treated as a word.
  always_comb begin
    wdata    = data;
    be       = 4'b1111;
    misalign = 1'b0;
    if (size == SIZE_BYTE) begin
      be    = 4'b0001 << offset;
      wdata = {4{data[7:0]}};
    end else if (size == SIZE_HALF) begin
      be       = offset[1] ? 4'b1100 : 4'b0011;
      wdata    = {2{data[15:0]}};
      misalign = offset[0];
    end else begin
      misalign = (offset != 2'b00);
    end
  end

endmodule

// File: rtl/store_align_buf.sv
// rtl/store_align_buf.sv - aligning store buffer feeding a word-wide write port
module store_align_buf
  import store_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_size,
  input  logic [31:0]                req_addr,
  input  logic [31:0]                req_data,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_be,
  output logic                       misalign,
  output logic [31:0]                misalign_addr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  store_entry_t   entries [DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [31:0]    al_wdata;
  logic [3:0]     al_be;
  logic           al_mis;
  logic           accept;
  logic           push;
  logic           pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  store_lane_align u_lane_align (
    .size     (req_size),
    .offset   (req_addr[1:0]),
    .data     (req_data),
    .wdata    (al_wdata),
    .be       (al_be),
    .misalign (al_mis)
  );

  // Full blocks requests even when a pop is in flight: no same-cycle slot reuse.
  assign req_ready = (count != CW'(DEPTH));
  assign accept    = req_valid && req_ready;
  assign push      = accept && !al_mis;
  assign mem_valid = (count != '0);
  assign pop       = mem_valid && mem_ready;

  assign mem_addr  = {entries[head].addr, 2'b00};
  assign mem_wdata = entries[head].wdata;
  assign mem_be    = entries[head].be;

  always_ff @(posedge clk) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      misalign <= accept && al_mis;
      if (accept && al_mis) misalign_addr <= req_addr;
    end
  end

  // Payload storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[tail] <= '{addr: req_addr[31:2], wdata: al_wdata, be: al_be};
    end
  end

endmodule

// File: tb/tb_store_align_buf.sv
// tb/tb_store_align_buf.sv - scoreboard bench for store_align_buf
module tb_store_align_buf;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        misalign;
  logic [31:0] misalign_addr;
  logic [1:0]  count;

  int    n_cmp = 0;
  int    n_err = 0;
  beat_t sb[$];
  beat_t exp_b;
  logic        hold_chk = 1'b0;
  logic [31:0] prev_addr;
  logic [31:0] prev_wdata;
  logic [3:0]  prev_be;

  store_align_buf #(.DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_size      (req_size),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .misalign      (misalign),
    .misalign_addr (misalign_addr),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Lane model: lane i of the write word carries byte (i mod width) of the data.
  function automatic void model(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                                output logic mis, output beat_t b);
    int lanes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    int off   = int'(a[1:0]);
    mis     = (off % lanes) != 0;
    b.addr  = {a[31:2], 2'b00};
    b.be    = '0;
    b.wdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (i / lanes == off / lanes) b.be[i] = 1'b1;
      b.wdata[8*i +: 8] = d[8*(i % lanes) +: 8];
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && mem_valid && mem_ready) begin
      if (sb.size() == 0) begin
        check("beat_unexpected", 32'd1, 32'd0);
      end else begin
        exp_b = sb.pop_front();
        check("beat_addr", mem_addr, exp_b.addr);
        check("beat_wdata", mem_wdata, exp_b.wdata);
        check("beat_be", 32'(mem_be), 32'(exp_b.be));
      end
    end
    if (hold_chk && !rst) begin
      check("hold_addr", mem_addr, prev_addr);
      check("hold_wdata", mem_wdata, prev_wdata);
      check("hold_be", 32'(mem_be), 32'(prev_be));
    end
    hold_chk   <= !rst && mem_valid && !mem_ready;
    prev_addr  <= mem_addr;
    prev_wdata <= mem_wdata;
    prev_be    <= mem_be;
  end

  task automatic send(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int    n = 0;
    logic  mis;
    beat_t b;
    req_valid = 1'b1;
    req_size  = sz;
    req_addr  = a;
    req_data  = d;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) begin
      check("req_accept_timeout", 32'd0, 32'd1);
    end else begin
      model(sz, a, d, mis, b);
      if (!mis) sb.push_back(b);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while (count != 0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("drain_count", 32'(count), 32'd0);
    check("drain_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_size  = 2'b00;
    req_addr  = '0;
    req_data  = '0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_misalign_addr", misalign_addr, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 mem_ready = 1'b1;

    send(2'b00, 32'h0000_1003, 32'h0000_00A5);
    @(negedge clk);
    check("byte_mem_valid", 32'(mem_valid), 32'd1);
    check("byte_mem_addr", mem_addr, 32'h0000_1000);
    check("byte_mem_be", 32'(mem_be), 32'h8);
    check("byte_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
    drain();

    send(2'b01, 32'h0000_2002, 32'h1234_BEEF);
    @(negedge clk);
    check("half_mem_be", 32'(mem_be), 32'hC);
    check("half_mem_wdata", mem_wdata, 32'hBEEF_BEEF);
    drain();

    send(2'b10, 32'h0000_3001, 32'hCAFE_F00D);
    @(negedge clk);
    check("mis_pulse", 32'(misalign), 32'd1);
    check("mis_count", 32'(count), 32'd0);
    check("mis_mem_valid", 32'(mem_valid), 32'd0);
    check("mis_addr", misalign_addr, 32'h0000_3001);
    @(negedge clk);
    check("mis_pulse_end", 32'(misalign), 32'd0);
    check("mis_addr_hold", misalign_addr, 32'h0000_3001);
    @(posedge clk);
    #1;
    send(2'b01, 32'h0000_2001, 32'h0000_1111);
    @(negedge clk);
    check("mis_half_pulse", 32'(misalign), 32'd1);
    check("mis_half_addr", misalign_addr, 32'h0000_2001);
    drain();

    mem_ready = 1'b0;
    send(2'b10, 32'h0000_4000, 32'h0102_0304);
    send(2'b00, 32'h0000_4005, 32'h0000_0077);
    fork
      send(2'b01, 32'h0000_4006, 32'h0000_9ABC);
      begin
        @(negedge clk);
        check("bp_count_full", 32'(count), 32'd2);
        check("bp_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("bp_still_full", 32'(count), 32'd2);
        @(posedge clk);
        #1 mem_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_while_popping_full", 32'(req_ready), 32'd0);
      end
    join
    drain();

    mem_ready = 1'b0;
    send(2'b10, 32'h0000_6000, 32'h1111_2222);
    mem_ready = 1'b1;
    send(2'b10, 32'h0000_6004, 32'h3333_4444);
    @(negedge clk);
    check("pushpop_count", 32'(count), 32'd1);
    check("pushpop_next_addr", mem_addr, 32'h0000_6004);
    drain();

    mem_ready = 1'b0;
    send(2'b10, 32'h0000_7000, 32'hAAAA_0000);
    send(2'b10, 32'h0000_7004, 32'hBBBB_0000);
    @(negedge clk);
    check("prerst_count", 32'(count), 32'd2);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    mem_ready = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_mem_valid", 32'(mem_valid), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_misalign_addr", misalign_addr, 32'd0);
    @(posedge clk);
    #1;
    send(2'b10, 32'h0000_5000, 32'hDEAD_BEEF);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/store_align_buf.md
STORE_ALIGN_BUF -- requirements
Module: store_align_buf

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning the number of store-buffer entries (power of two, 2..8).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset that is synchronous and active-high.
REQ-004 The block SHALL have port req_valid, input, 1 bit, store request present.
REQ-005 The block SHALL have port req_ready, output, 1 bit, block can take a request.
REQ-006 The block SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 1x word.
REQ-007 The block SHALL have port req_addr, input, 32 bits, byte address.
REQ-008 The block SHALL have port req_data, input, 32 bits, store value, right-justified.
REQ-009 The block SHALL have port mem_valid, output, 1 bit, write beat present.
REQ-010 The block SHALL have port mem_ready, input, 1 bit, memory accepts the beat.
REQ-011 The block SHALL have port mem_addr, output, 32 bits, word address with bits [1:0] forced to 00.
REQ-012 The block SHALL have port mem_wdata, output, 32 bits, lane-aligned data.
REQ-013 The block SHALL have port mem_be, output, 4 bits, byte-lane enables, bit i = byte lane i.
REQ-014 The block SHALL have port misalign, output, 1 bit, one-cycle fault pulse.
REQ-015 The block SHALL have port misalign_addr, output, 32 bits, address of the last faulting request.
REQ-016 The block SHALL have port count, output, $clog2(DEPTH)+1 bits, occupied entries.

Function
REQ-017 A request SHALL be accepted on a cycle with req_valid && req_ready, where req_ready = (count != DEPTH), independent of mem_ready.
REQ-018 Byte store lanes SHALL be: mem_be = 4'b0001 << addr[1:0], and mem_wdata = {4{data[7:0]}}.
REQ-019 Half store lanes SHALL be: mem_be = addr[1] ? 1100 : 0011, and mem_wdata = {2{data[15:0]}}.
REQ-020 Word store lanes SHALL be: mem_be = 1111, and mem_wdata = data.
REQ-021 A half with addr[0]=1, or a word with addr[1:0]!=00, SHALL be misaligned: accepted, but not enqueued.
REQ-022 For a misaligned request, misalign SHALL be 1 on the following cycle only, and misalign_addr SHALL be loaded with req_addr.
REQ-023 misalign_addr SHALL hold its value until the next fault.
REQ-024 An aligned accepted request SHALL be written to the tail entry, and count SHALL increment.
REQ-025 The earliest that entry SHALL appear on mem_* is the next cycle; the buffer has no same-cycle bypass.
REQ-026 mem_valid SHALL equal (count != 0), with mem_addr/mem_wdata/mem_be driven from the head entry.
REQ-027 A beat SHALL complete on mem_valid && mem_ready, then the head pointer advances and count decrements.
REQ-028 While mem_valid && !mem_ready, all mem_* outputs SHALL hold stable.
REQ-029 When a push and a pop occur in the same cycle, count SHALL be unchanged and both pointers SHALL advance.
REQ-030 Head and tail pointers SHALL wrap from DEPTH-1 to 0.
REQ-031 When full, req_ready SHALL be 0 even if a pop occurs in that cycle; a new request is accepted the cycle after.
REQ-032 Beats SHALL leave in strict acceptance order, with no merging or reordering.
REQ-033 A misaligned request arriving while the buffer is full SHALL wait for req_ready like any other request.

Reset
REQ-034 When rst is 1 at a clock edge, the following SHALL be cleared: count=0, pointers=0, mem_valid=0, misalign=0, misalign_addr=0.
REQ-035 Reset during a pending beat SHALL discard all entries; no beat completes in the reset cycle.
REQ-036 Entry data storage SHALL need no reset.
REQ-037 req_ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-038 Shared package store_pkg SHALL hold the SIZE_BYTE/SIZE_HALF/SIZE_WORD encodings.
REQ-039 Shared package store_pkg SHALL hold the entry struct {addr[31:2], wdata, be}.
REQ-040 A combinational sub-module store_lane_align SHALL implement REQ-018..REQ-021 (lane align, byte-enable generation, misalign detect).
REQ-041 The FIFO and control logic SHALL sit in store_align_buf.

Verification
REQ-042 The bench SHALL cover byte store: addr 0x1003, data 0x000000A5, size 00 -> next cycle mem_valid=1, mem_addr=0x1000, mem_be=1000, mem_wdata=0xA5A5A5A5.
REQ-043 The bench SHALL cover half store: addr 0x2002, data 0x1234BEEF, size 01 -> mem_be=1100, mem_wdata=0xBEEFBEEF.
REQ-044 The bench SHALL cover misalign: word at 0x3001 -> nothing enqueued, count stays 0, misalign=1 for exactly one cycle, misalign_addr=0x3001.
REQ-045 The bench SHALL cover backpressure: mem_ready=0, DEPTH=2, three requests -> count=2, req_ready=0, third held. Then mem_ready=1 -> beats leave in order, third accepted, pointer wraps.
REQ-046 The bench SHALL cover simultaneous push/pop: count=1, push and pop in the same cycle -> count stays 1, and the next beat is the new entry.
REQ-047 The bench SHALL cover reset mid-operation: count=2 with mem_ready=0, assert rst for one cycle -> mem_valid=0, count=0, req_ready=1 after release.
